// File: rtl/io_mmio_deco.sv
// Registered MMIO region decoder with debounced button status register and sticky unmapped-access capture.
// Selects and status appear one cycle after req; no backpressure (every strobe is accepted).
module io_mmio_deco #(
   parameter int unsigned ADDR_W         = 22,
   parameter int unsigned MEM_TOP        = 96,
   parameter int unsigned SHOW_ORIG_ADDR = 100,
   parameter int unsigned BTN_ADDR       = 104,
   parameter int unsigned SHOW_ADDR      = 116,
   parameter int unsigned PROC_BASE      = 120,
   parameter int unsigned ORIG_BASE      = 160120,
   parameter int unsigned ORIG_TOP       = 320120,
   parameter int unsigned NUM_BTN        = 4,
   parameter int unsigned DEB_CYC        = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR_W-1:0]          addr,
   input  logic                       req,
   input  logic                       we,
   input  logic [NUM_BTN-1:0]         btn_raw,
   output logic                       mem_enb,
   output logic                       show_original_enb,
   output logic                       show_enb,
   output logic                       process_enb,
   output logic                       original_enb,
   output logic [NUM_BTN-1:0]         btn_rdata,
   output logic [$clog2(NUM_BTN)-1:0] btn_selecc,
   output logic                       btn_valid,
   output logic                       err,
   output logic [ADDR_W-1:0]          err_addr
);

   localparam int unsigned SEL_W = $clog2(NUM_BTN);
   localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);

   localparam logic [ADDR_W-1:0] A_MEM_TOP   = ADDR_W'(MEM_TOP);
   localparam logic [ADDR_W-1:0] A_SHOW_ORIG = ADDR_W'(SHOW_ORIG_ADDR);
   localparam logic [ADDR_W-1:0] A_BTN       = ADDR_W'(BTN_ADDR);
   localparam logic [ADDR_W-1:0] A_SHOW      = ADDR_W'(SHOW_ADDR);
   localparam logic [ADDR_W-1:0] A_PROC      = ADDR_W'(PROC_BASE);
   localparam logic [ADDR_W-1:0] A_ORIG      = ADDR_W'(ORIG_BASE);
   localparam logic [ADDR_W-1:0] A_ORIG_TOP  = ADDR_W'(ORIG_TOP);
   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEB_CYC - 1);

   // en bit order: mem, show_original, show, process, original
   logic [4:0]         sel_dec, en_d, en_q;
   logic               hit_btn, unmapped;
   logic               status_rd, status_wr, err_set;

   logic [NUM_BTN-1:0] sync1_q, sync2_q;
   logic [NUM_BTN-1:0] deb_d, deb_q, rise;
   logic [CNT_W-1:0]   cnt_d [NUM_BTN];
   logic [CNT_W-1:0]   cnt_q [NUM_BTN];
   logic [NUM_BTN-1:0] pend_d, pend_q, rdata_d, rdata_q;
   logic [SEL_W-1:0]   selecc_d, selecc_q;
   logic               valid_d, valid_q;
   logic               err_d, err_q;
   logic [ADDR_W-1:0]  eaddr_d, eaddr_q;

   // Priority chain resolves any parameter overlap in the documented order.
   always_comb begin
      sel_dec  = '0;
      hit_btn  = 1'b0;
      unmapped = 1'b0;
      if (addr <= A_MEM_TOP)                          sel_dec[0] = 1'b1;
      else if (addr == A_SHOW_ORIG)                   sel_dec[1] = 1'b1;
      else if (addr == A_BTN)                         hit_btn    = 1'b1;
      else if (addr == A_SHOW)                        sel_dec[2] = 1'b1;
      else if (addr >= A_PROC && addr < A_ORIG)       sel_dec[3] = 1'b1;
      else if (addr >= A_ORIG && addr <= A_ORIG_TOP)  sel_dec[4] = 1'b1;
      else                                            unmapped   = 1'b1;
   end

   assign en_d      = req ? sel_dec : '0;
   assign status_rd = req & ~we & hit_btn;
   assign status_wr = req &  we & hit_btn;
   assign err_set   = req & unmapped;

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // A press accepted in the same cycle as a status read survives the read-clear.
   assign rise    = deb_d & ~deb_q;
   assign pend_d  = status_rd ? rise : (pend_q | rise);
   assign rdata_d = status_rd ? pend_q : rdata_q;
   assign valid_d = |pend_d;

   always_comb begin
      selecc_d = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pend_d[i]) selecc_d = SEL_W'(i);
      end
   end

   always_comb begin
      err_d   = err_q;
      eaddr_d = eaddr_q;
      if (status_wr) begin
         err_d   = 1'b0;
         eaddr_d = '0;
      end else if (err_set) begin
         err_d = 1'b1;
         if (!err_q) eaddr_d = addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q     <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         deb_q    <= '0;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
         pend_q   <= '0;
         rdata_q  <= '0;
         selecc_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         eaddr_q  <= '0;
      end else begin
         en_q     <= en_d;
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
         pend_q   <= pend_d;
         rdata_q  <= rdata_d;
         selecc_q <= selecc_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         eaddr_q  <= eaddr_d;
      end
   end

   assign mem_enb           = en_q[0];
   assign show_original_enb = en_q[1];
   assign show_enb          = en_q[2];
   assign process_enb       = en_q[3];
   assign original_enb      = en_q[4];
   assign btn_rdata         = rdata_q;
   assign btn_selecc        = selecc_q;
   assign btn_valid         = valid_q;
   assign err               = err_q;
   assign err_addr          = eaddr_q;

endmodule

// File: tb/tb_io_mmio_deco.sv
// Bench for io_mmio_deco: directed scenarios plus randomized traffic against a behavioural model.
module tb_io_mmio_deco;

   localparam int ADDR_W = 22, MEM_TOP = 96, SO = 100, BTN = 104, SHOW = 116;
   localparam int PROC = 120, ORIG = 160120, TOP = 320120, NB = 4, DEB = 4;
   localparam int LO [5] = '{0, SO, SHOW, PROC, ORIG};
   localparam int HI [5] = '{MEM_TOP, SO, SHOW, ORIG - 1, TOP};
   localparam int BND [18] = '{0, 96, 97, 99, 100, 101, 103, 104, 105, 115, 116, 117,
                               119, 120, 160119, 160120, 320120, 320121};
   localparam int P1A [5] = '{0, 96, 97, 100, 116};
   localparam int P1E [5] = '{1, 1, 0, 2, 4};
   localparam int P2A [6] = '{119, 120, 160119, 160120, 320120, 320121};
   localparam int P2E [6] = '{0, 8, 8, 16, 16, 0};

   logic              clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [NB-1:0]     btn_raw = '0;
   logic mem_enb, show_original_enb, show_enb, process_enb, original_enb, btn_valid, err;
   logic [NB-1:0]     btn_rdata;
   logic [1:0]        btn_selecc;
   logic [ADDR_W-1:0] err_addr;
   logic [4:0]        en_vec;

   int checks = 0, errors = 0;

   io_mmio_deco dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .req(req), .we(we), .btn_raw(btn_raw),
      .mem_enb(mem_enb), .show_original_enb(show_original_enb), .show_enb(show_enb),
      .process_enb(process_enb), .original_enb(original_enb), .btn_rdata(btn_rdata),
      .btn_selecc(btn_selecc), .btn_valid(btn_valid), .err(err), .err_addr(err_addr)
   );

   assign en_vec = {original_enb, process_enb, show_enb, show_original_enb, mem_enb};

   always #5 clk = ~clk;

   // Behavioural model: region table lookup, raw-sample history and a sliding stability window.
   logic [4:0]    m_en;
   logic          m_err;
   int            m_eaddr;
   logic [NB-1:0] m_pend, m_rdata, m_deb;
   logic [NB-1:0] m_seen [$];
   logic [NB-1:0] m_win [DEB];

   function automatic int region(int a);
      if (a >= LO[0] && a <= HI[0]) return 0;
      if (a >= LO[1] && a <= HI[1]) return 1;
      if (a == BTN) return 5;
      for (int r = 2; r < 5; r++) if (a >= LO[r] && a <= HI[r]) return r;
      return 6;
   endfunction

   function automatic int lowest(logic [NB-1:0] p);
      for (int i = 0; i < NB; i++) if (p[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_en = '0; m_err = 1'b0; m_eaddr = 0;
      m_pend = '0; m_rdata = '0; m_deb = '0;
      m_seen = {};
      m_seen.push_back('0);
      m_seen.push_back('0);
      for (int j = 0; j < DEB; j++) m_win[j] = '0;
   endtask

   task automatic model_step();
      logic [NB-1:0] synced, rise;
      bit            all_diff;
      int            r;
      synced = m_seen.pop_front();
      m_seen.push_back(btn_raw);
      for (int j = 0; j < DEB - 1; j++) m_win[j] = m_win[j+1];
      m_win[DEB-1] = synced;
      rise = '0;
      for (int b = 0; b < NB; b++) begin
         all_diff = 1'b1;
         for (int j = 0; j < DEB; j++) if (m_win[j][b] == m_deb[b]) all_diff = 1'b0;
         if (all_diff) begin
            m_deb[b] = ~m_deb[b];
            if (m_deb[b]) rise[b] = 1'b1;
         end
      end
      r = req ? region(int'(addr)) : -1;
      m_en = (r >= 0 && r <= 4) ? 5'(1 << r) : 5'd0;
      if (r == 5 && !we) begin
         m_rdata = m_pend;
         m_pend  = rise;
      end else begin
         m_pend = m_pend | rise;
      end
      if (r == 5 && we) begin
         m_err = 1'b0; m_eaddr = 0;
      end
      if (r == 6) begin
         if (!m_err) m_eaddr = int'(addr);
         m_err = 1'b1;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      cmp({tag, "/en"}, 32'(en_vec), 32'(m_en));
      cmp({tag, "/rdata"}, 32'(btn_rdata), 32'(m_rdata));
      cmp({tag, "/valid"}, 32'(btn_valid), 32'(|m_pend));
      cmp({tag, "/selecc"}, 32'(btn_selecc), 32'(lowest(m_pend)));
      cmp({tag, "/err"}, 32'(err), 32'(m_err));
      cmp({tag, "/err_addr"}, 32'(err_addr), m_eaddr);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_all("cyc");
   endtask

   task automatic access(int a, logic w);
      req = 1'b1; addr = ADDR_W'(a); we = w;
      tick();
      req = 1'b0; we = 1'b0;
   endtask

   initial begin
      int n, k;
      repeat (3) tick();
      cmp("rst_en", 32'(en_vec), 0);
      cmp("rst_btn", 32'({btn_rdata, btn_selecc, btn_valid, err}), 0);
      cmp("rst_eaddr", 32'(err_addr), 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         access(P1A[i], 1'b0);
         cmp("p1_en", 32'(en_vec), P1E[i]);
      end
      cmp("p1_err", 32'(err), 1);
      cmp("p1_eaddr", 32'(err_addr), 97);
      tick();
      cmp("p1_pulse_end", 32'(en_vec), 0);

      access(BTN, 1'b1);
      for (int i = 0; i < 6; i++) begin
         access(P2A[i], 1'b0);
         cmp("p2_en", 32'(en_vec), P2E[i]);
      end
      cmp("p2_err", 32'(err), 1);
      cmp("p2_eaddr", 32'(err_addr), 119);
      access(BTN, 1'b1);
      cmp("p2_clr_err", 32'(err), 0);
      cmp("p2_clr_eaddr", 32'(err_addr), 0);

      btn_raw = 4'b0100;
      repeat (3) tick();
      btn_raw = '0;
      repeat (10) tick();
      cmp("p3_glitch", 32'(btn_valid), 0);
      btn_raw = 4'b0100;
      n = 0;
      while (btn_valid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      cmp("p3_valid", 32'(btn_valid), 1);
      cmp("p3_selecc", 32'(btn_selecc), 2);
      repeat (10 - n) tick();
      btn_raw = '0;
      repeat (8) tick();

      access(BTN, 1'b0);
      cmp("p4_rd0", 32'(btn_rdata), 4);
      btn_raw = 4'b1010;
      repeat (8) tick();
      btn_raw = '0;
      repeat (8) tick();
      cmp("p4_sel1", 32'(btn_selecc), 1);
      access(BTN, 1'b0);
      cmp("p4_rdata", 32'(btn_rdata), 10);
      cmp("p4_valid0", 32'(btn_valid), 0);
      btn_raw = 4'b1010;
      repeat (8) tick();
      btn_raw = 4'b1011;
      repeat (5) tick();
      access(BTN, 1'b0);
      cmp("p4_rd_coinc", 32'(btn_rdata), 10);
      cmp("p4_valid1", 32'(btn_valid), 1);
      cmp("p4_sel0", 32'(btn_selecc), 0);
      btn_raw = '0;
      repeat (8) tick();

      access(97, 1'b0);
      for (int i = 0; i < 5; i++) begin
         addr = ADDR_W'($urandom_range(0, 400000));
         we = 1'($urandom);
         tick();
         cmp("p5_idle_en", 32'(en_vec), 0);
         cmp("p5_err", 32'(err), 1);
      end
      we = 1'b0;

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) btn_raw = NB'($urandom);
         k = $urandom_range(0, 3);
         case (k)
            0:       addr = ADDR_W'(BND[$urandom_range(0, 17)]);
            1:       addr = ADDR_W'($urandom_range(0, 400000));
            2:       addr = ADDR_W'($urandom);
            default: addr = ADDR_W'(BTN);
         endcase
         req = ($urandom_range(0, 2) != 0);
         we  = 1'($urandom);
         tick();
      end
      req = 1'b0; we = 1'b0;
      btn_raw = '0;
      repeat (8) tick();

      access(BTN, 1'b0);
      btn_raw = 4'b0100;
      repeat (8) tick();
      btn_raw = '0;
      repeat (8) tick();
      cmp("p6_pend", 32'({btn_valid, btn_selecc}), 6);
      access(SHOW, 1'b0);
      cmp("p6_show", 32'(show_enb), 1);
      #2 rst_n = 1'b0;
      #1;
      cmp("p6_rst_en", 32'(en_vec), 0);
      cmp("p6_rst_btn", 32'({btn_rdata, btn_selecc, btn_valid, err}), 0);
      cmp("p6_rst_eaddr", 32'(err_addr), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      cmp("p6_no_en", 32'(en_vec), 0);
      cmp("p6_no_pend", 32'(btn_valid), 0);
      access(0, 1'b0);
      cmp("p6_new_req", 32'(mem_enb), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_mmio_deco.md
Name: io_mmio_deco

Overview:
Parametrised, registered memory-mapped IO decoder for the single-cycle processor's data bus. It steers each bus access to one of five regions: data memory, show-original, show-processed, process buffer, original image. It adds a button status register with synchronisers, debouncing and pending-press latching read-cleared by software, plus a sticky unmapped-access error capture. It sits between the core's data address/strobe outputs and the memory/VGA/button subsystems.

Parameters:
ADDR_W, 22, bus address width
MEM_TOP, 96, highest data-memory address (region 0..MEM_TOP inclusive)
SHOW_ORIG_ADDR, 100, show-original command address
BTN_ADDR, 104, button status register address
SHOW_ADDR, 116, show-processed command address
PROC_BASE, 120, process buffer base (inclusive)
ORIG_BASE, 160120, original image base (inclusive); process region is PROC_BASE..ORIG_BASE-1
ORIG_TOP, 320120, original image last address (inclusive)
NUM_BTN, 4, number of push buttons (>=2)
DEB_CYC, 4, consecutive stable cycles required to accept a button level (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_W  bus address
req  in  1  access strobe, one cycle per access
we  in  1  1 = write, 0 = read
btn_raw  in  NUM_BTN  asynchronous button levels, active high
mem_enb  out  1  data memory select
show_original_enb  out  1  show-original select
show_enb  out  1  show-processed select
process_enb  out  1  process buffer select
original_enb  out  1  original image select
btn_rdata  out  NUM_BTN  pending-press vector returned by status read
btn_selecc  out  $clog2(NUM_BTN)  index of lowest pending button
btn_valid  out  1  any press pending
err  out  1  sticky unmapped-access flag
err_addr  out  ADDR_W  address of first unmapped access

Behaviour:
- Reset: every output 0; pending, debounced state, counters, synchronisers 0.
- Decode: on req=1, regions evaluated per parameters (unsigned compare); result registered; exactly one *_enb high for one cycle, cycle N+1 after req at N. req=0 -> all enables 0 next cycle. we does not affect region selects.
- Parameter regions must not overlap; on overlap, priority mem > show_original > BTN_ADDR > show > process > original.
- Address ORIG_TOP selects original; ORIG_TOP+1 is unmapped. ORIG_BASE-1 selects process.
- Buttons: 2-flop synchroniser per bit. Per-button counter resets when synced level equals debounced state; else increments; on reaching DEB_CYC debounced state takes the synced level, counter clears. Glitch shorter than DEB_CYC cycles never changes state.
- Debounced 0->1 edge sets pending bit. Release sets nothing.
- Status read (req=1, we=0, addr=BTN_ADDR) at cycle N: btn_rdata = pending as sampled at N, valid cycle N+1, held until next status read; pending bits returned are cleared at N+1. A press edge in cycle N survives the clear (set wins).
- btn_valid = |pending; btn_selecc = lowest set index, 0 when none. Both registered from pending.
- Status write (req=1, we=1, addr=BTN_ADDR): clears err and err_addr at N+1; pending untouched.
- Unmapped access (req=1, no region, not BTN_ADDR): err=1 at N+1, err_addr captured only if err was 0; later errors do not overwrite. Error and clear in same cycle impossible (distinct addresses).
- rst_n low mid-access: all state cleared asynchronously; enable pulse aborted; no pending survives.

Test Plan:
- req with addr=0, 96, 97, 100, 116 -> mem_enb, mem_enb, err=1/err_addr=97, show_original_enb, show_enb each exactly one cycle later; others 0.
- addr=119, 120, 160119, 160120, 320120, 320121 -> err(119 captured), process, process, original, original; err_addr stays 119; write to 104 clears err/err_addr to 0.
- btn_raw[2] high 3 cycles then low (DEB_CYC=4) -> no pending; held 10 cycles -> btn_valid=1, btn_selecc=2 within sync+DEB_CYC+2 cycles.
- Pending 4'b1010, status read -> btn_rdata=4'b1010, btn_valid=0 next cycle; btn[0] press edge coincident with read -> btn_rdata excludes it, pending=4'b0001 afterwards, btn_selecc=0.
- req=0 for 5 cycles with addr sweeping -> all enables stay 0, err unchanged.
- rst_n low during show_enb pulse and with pending=4'b0100 -> all outputs 0 immediately; after release, no enable until new req.
